// File: rtl/fft_src_stream.sv
// Multi-frame sample feeder for the burst FFT core: optional config word, then
// N frames read from a 1-cycle-latency source memory, streamed through a 2-entry skid FIFO.
module fft_src_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10,
    parameter int FRM_WIDTH  = 8,
    parameter int CFG_WIDTH  = 24,
    parameter int CFG_EN     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fft_start,
    input  logic [LEN_WIDTH-1:0]    frame_len,
    input  logic [FRM_WIDTH-1:0]    frame_num,
    input  logic                    addr_mode,
    input  logic                    fwd_inv,
    input  logic [CFG_WIDTH-2:0]    cfg_sch,
    output logic                    cfg_valid,
    output logic [CFG_WIDTH-1:0]    cfg_data,
    input  logic                    cfg_ready,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    output logic                    rom_rd_en,
    input  logic [DATA_WIDTH-1:0]   rom_data,
    output logic [2*DATA_WIDTH-1:0] s_axi_data,
    output logic                    s_axi_valid,
    output logic                    s_axi_last,
    input  logic                    s_axi_ready,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, CFG, READ, DRAIN} state_t;

    state_t                  state;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [FRM_WIDTH-1:0]    num_q;
    logic                    mode_q;
    logic [LEN_WIDTH-1:0]    sample_cnt;
    logic [FRM_WIDTH-1:0]    frame_cnt;
    logic [ADDR_WIDTH-1:0]   frame_base;
    logic                    rd_pend;
    logic                    pend_last;

    logic [DATA_WIDTH-1:0]   fifo_data [2];
    logic                    fifo_last [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              count;

    logic                    push;
    logic                    pop;
    logic [2:0]              occ;
    logic                    frame_end;

    assign push      = rd_pend;
    assign pop       = s_axi_valid && s_axi_ready;
    assign frame_end = (sample_cnt == len_q);

    // Credit counts the beat leaving this cycle so the stream runs back-to-back.
    assign occ       = {1'b0, count} + {2'b00, rd_pend} - {2'b00, pop};
    assign rom_rd_en = (state == READ) && (occ < 3'd2);
    assign rom_addr  = frame_base + ADDR_WIDTH'(sample_cnt);

    assign s_axi_valid = (count != 2'd0);
    assign s_axi_data  = {{DATA_WIDTH{1'b0}}, fifo_data[rd_ptr]};
    assign s_axi_last  = fifo_last[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            num_q      <= '0;
            mode_q     <= 1'b0;
            cfg_data   <= '0;
            cfg_valid  <= 1'b0;
            sample_cnt <= '0;
            frame_cnt  <= '0;
            frame_base <= '0;
            rd_pend    <= 1'b0;
            pend_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done    <= 1'b0;
            rd_pend <= rom_rd_en;
            case (state)
                IDLE: begin
                    if (fft_start) begin
                        len_q      <= frame_len;
                        num_q      <= frame_num;
                        mode_q     <= addr_mode;
                        cfg_data   <= {cfg_sch, fwd_inv};
                        sample_cnt <= '0;
                        frame_cnt  <= '0;
                        frame_base <= '0;
                        busy       <= 1'b1;
                        cfg_valid  <= (CFG_EN != 0);
                        state      <= (CFG_EN != 0) ? CFG : READ;
                    end
                end
                CFG: begin
                    if (cfg_ready) begin
                        cfg_valid <= 1'b0;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (rom_rd_en) begin
                        pend_last <= frame_end;
                        if (frame_end) begin
                            sample_cnt <= '0;
                            frame_cnt  <= frame_cnt + 1'b1;
                            if (mode_q)
                                frame_base <= frame_base + ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1);
                            if (frame_cnt == num_q)
                                state <= DRAIN;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Finish on the cycle the final beat leaves, so done lands right after it.
                    if (!rd_pend && count == 2'd1 && pop) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the two FIFO entries are reset because they drive s_axi_data/last
    // directly and those outputs must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rom_data;
                fifo_last[wr_ptr] <= pend_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
